// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned INSTBUS         = 48;
    localparam int unsigned FBUF_W          = 96;

    // Bus words are little-endian; the fetch buffer holds bytes in address order, MSB first.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/inst_align.sv
// Picks the 6 instruction bytes starting at a byte offset of the 3-word fetch buffer.
module inst_align
    import mem_arbiter_pkg::*;
(
    input  logic [FBUF_W-1:0]  fbuf_i,
    input  logic [1:0]         off_i,
    output logic [INSTBUS-1:0] inst_o
);

    always_comb begin
        inst_o = '0;
        unique case (off_i)
            2'd0: inst_o = fbuf_i[95:48];
            2'd1: inst_o = fbuf_i[87:40];
            2'd2: inst_o = fbuf_i[79:32];
            2'd3: inst_o = fbuf_i[71:24];
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory bus between instruction fetch and data access,
// data first, with a watchdog that aborts hung beats.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [INSTBUS-1:0] if_inst,
    output logic               if_valid,
    input  logic               dm_read,
    input  logic               dm_write,
    input  logic [31:0]        dm_addr,
    input  logic [31:0]        dm_wdata,
    output logic [31:0]        dm_rdata,
    output logic               dm_valid,
    output logic               stall_o,
    output logic               err_o,
    output logic               bus_req,
    output logic               bus_we,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wdata,
    input  logic [31:0]        bus_rdata,
    input  logic               bus_ack
);

    localparam int unsigned        WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]     WD_LAST = WDW'(TIMEOUT - 1);

    state_e               state_q;
    logic [1:0]           beat_q, last_beat_q, off_q;
    logic [FBUF_W-1:0]    fbuf_q, fbuf_d;
    logic [WDW-1:0]       wd_q;
    logic                 bus_req_q, bus_we_q, if_valid_q, dm_valid_q, err_q;
    logic [31:0]          bus_addr_q, bus_wdata_q, dm_rdata_q;
    logic [INSTBUS-1:0]   if_inst_q, inst_d;
    logic                 ack, timeout;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^dm_addr[1:0];

    assign ack     = bus_req_q & bus_ack;
    assign timeout = bus_req_q & ~bus_ack & (wd_q == WD_LAST);

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_inst   = if_inst_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign err_o     = err_q;

    assign stall_o = (if_req & ~if_valid_q) | ((dm_read | dm_write) & ~dm_valid_q);

    // Buffer view including the word arriving this cycle, so the last ack can
    // register the aligned instruction without an extra cycle.
    always_comb begin
        fbuf_d = fbuf_q;
        unique case (beat_q)
            2'd0:    fbuf_d[95:64] = bswap32(bus_rdata);
            2'd1:    fbuf_d[63:32] = bswap32(bus_rdata);
            default: fbuf_d[31:0]  = bswap32(bus_rdata);
        endcase
    end

    inst_align u_inst_align (
        .fbuf_i (fbuf_d),
        .off_i  (off_q),
        .inst_o (inst_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            last_beat_q <= '0;
            off_q       <= '0;
            fbuf_q      <= '0;
            wd_q        <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_inst_q   <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dm_read || dm_write) begin
                        state_q     <= DATA;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= dm_write;
                        bus_addr_q  <= {dm_addr[31:2], 2'b00};
                        bus_wdata_q <= dm_wdata;
                        wd_q        <= '0;
                    end else if (if_req) begin
                        state_q     <= FETCH;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= {if_addr[31:2], 2'b00};
                        off_q       <= if_addr[1:0];
                        last_beat_q <= (if_addr[1:0] == 2'd3) ? 2'd2 : 2'd1;
                        beat_q      <= '0;
                        fbuf_q      <= '0;
                        wd_q        <= '0;
                    end
                end
                DATA: begin
                    if (ack) begin
                        bus_req_q  <= 1'b0;
                        dm_valid_q <= 1'b1;
                        wd_q       <= '0;
                        state_q    <= RESP;
                        if (!bus_we_q) dm_rdata_q <= bus_rdata;
                    end else if (timeout) begin
                        bus_req_q  <= 1'b0;
                        err_q      <= 1'b1;
                        dm_valid_q <= 1'b1;
                        dm_rdata_q <= '0;
                        wd_q       <= '0;
                        state_q    <= RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                FETCH: begin
                    if (ack) begin
                        fbuf_q <= fbuf_d;
                        wd_q   <= '0;
                        if (beat_q == last_beat_q) begin
                            bus_req_q  <= 1'b0;
                            if_inst_q  <= inst_d;
                            if_valid_q <= 1'b1;
                            beat_q     <= '0;
                            state_q    <= RESP;
                        end else begin
                            beat_q     <= beat_q + 2'd1;
                            bus_addr_q <= bus_addr_q + 32'd4;
                        end
                    end else if (timeout) begin
                        bus_req_q  <= 1'b0;
                        err_q      <= 1'b1;
                        if_valid_q <= 1'b1;
                        if_inst_q  <= '0;
                        beat_q     <= '0;
                        wd_q       <= '0;
                        state_q    <= RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                RESP: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small wait-state bus model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [47:0] if_inst;
    logic        if_valid;
    logic        dm_read, dm_write;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_valid, stall_o, err_o;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    logic [95:0] al_buf;
    logic [1:0]  al_off;
    logic [47:0] al_inst;

    int unsigned tests = 0;
    int unsigned fails = 0;

    int unsigned waits  = 0;
    bit          ack_en = 1'b1;
    int unsigned wcnt   = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .stall_o   (stall_o),
        .err_o     (err_o),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    inst_align u_align (
        .fbuf_i (al_buf),
        .off_i  (al_off),
        .inst_o (al_inst)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h33221100;
            32'h104: return 32'h77665544;
            32'h108: return 32'hBBAA9988;
            32'h200: return 32'hDEADBEEF;
            default: return a ^ 32'hA5A5A5A5;
        endcase
    endfunction

    assign bus_ack   = bus_req && ack_en && (wcnt == waits);
    assign bus_rdata = mem_word(bus_addr);

    always @(posedge clk) begin
        if (bus_req && !bus_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (bus_req && bus_ack && bus_we) begin
            wr_addr <= bus_addr;
            wr_data <= bus_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [47:0] al_exp [4];
    bit ok;

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0;
        al_buf = 96'h0011_2233_4455_6677_8899_AABB; al_off = 2'd0;

        // Standalone byte extraction
        al_exp[0] = 48'h001122334455; al_exp[1] = 48'h112233445566;
        al_exp[2] = 48'h223344556677; al_exp[3] = 48'h334455667788;
        for (int i = 0; i < 4; i++) begin
            al_off = 2'(i);
            #1;
            chk("align_off", {16'h0, al_inst}, {16'h0, al_exp[i]});
        end

        // Reset state
        step(); step(); step();
        chk("rst_bus_req",  64'(bus_req),  64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_dm_valid", 64'(dm_valid), 64'd0);
        chk("rst_err",      64'(err_o),    64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_if_inst",  64'(if_inst),  64'd0);
        chk("rst_stall",    64'(stall_o),  64'd0);
        rst = 1'b1;
        step();

        // Aligned 2-beat fetch, zero wait
        if_addr = 32'h100; if_req = 1'b1;
        #1 chk("al_stall_n", 64'(stall_o), 64'd1);
        step();
        chk("al_req_n1",  64'(bus_req),  64'd1);
        chk("al_addr_n1", 64'(bus_addr), 64'h100);
        chk("al_stall_n1", 64'(stall_o), 64'd1);
        step();
        chk("al_addr_n2", 64'(bus_addr), 64'h104);
        chk("al_stall_n2", 64'(stall_o), 64'd1);
        chk("al_valid_n2", 64'(if_valid), 64'd0);
        step();
        chk("al_valid_n3", 64'(if_valid), 64'd1);
        chk("al_inst",     64'(if_inst),  64'h001122334455);
        chk("al_stall_n3", 64'(stall_o),  64'd0);
        chk("al_req_n3",   64'(bus_req),  64'd0);
        if_req = 1'b0;
        step();
        chk("al_valid_pulse", 64'(if_valid), 64'd0);

        // Offset-3 fetch: three beats
        if_addr = 32'h103; if_req = 1'b1;
        step(); chk("o3_addr_b0", 64'(bus_addr), 64'h100);
        step(); chk("o3_addr_b1", 64'(bus_addr), 64'h104);
        step(); chk("o3_addr_b2", 64'(bus_addr), 64'h108);
        chk("o3_valid_n3", 64'(if_valid), 64'd0);
        step();
        chk("o3_valid_n4", 64'(if_valid), 64'd1);
        chk("o3_inst",     64'(if_inst),  64'h334455667788);
        if_req = 1'b0;
        step();

        // Simultaneous data read and fetch: data first
        dm_addr = 32'h201; dm_read = 1'b1; if_addr = 32'h100; if_req = 1'b1;
        step();
        chk("pr_addr", 64'(bus_addr), 64'h200);
        chk("pr_we",   64'(bus_we),   64'd0);
        step();
        chk("pr_dm_valid", 64'(dm_valid), 64'd1);
        chk("pr_rdata",    64'(dm_rdata), 64'hDEADBEEF);
        chk("pr_if_valid", 64'(if_valid), 64'd0);
        chk("pr_stall",    64'(stall_o),  64'd1);
        dm_read = 1'b0;
        step();
        chk("pr_idle_req", 64'(bus_req), 64'd0);
        step();
        chk("pr_f_req",  64'(bus_req),  64'd1);
        chk("pr_f_addr", 64'(bus_addr), 64'h100);
        step(); step();
        chk("pr_f_valid", 64'(if_valid), 64'd1);
        chk("pr_f_inst",  64'(if_inst),  64'h001122334455);
        if_req = 1'b0;
        step();

        // Write with 3 wait states
        waits = 3;
        dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_write = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h40 ||
                bus_wdata !== 32'h12345678 || dm_valid !== 1'b0) ok = 1'b0;
        end
        chk("wr_stable", 64'(ok), 64'd1);
        step();
        chk("wr_valid_n5", 64'(dm_valid), 64'd1);
        chk("wr_bus_addr", 64'(wr_addr),  64'h40);
        chk("wr_bus_data", 64'(wr_data),  64'h12345678);
        dm_write = 1'b0;
        waits = 0;
        step();

        // Watchdog on a data read that never acks
        ack_en = 1'b0;
        dm_addr = 32'h300; dm_read = 1'b1;
        step();
        chk("wd_req", 64'(bus_req), 64'd1);
        ok = 1'b1;
        for (int i = 0; i < 63; i++) begin
            step();
            if (bus_req !== 1'b1 || err_o !== 1'b0 || dm_valid !== 1'b0) ok = 1'b0;
        end
        chk("wd_hold", 64'(ok), 64'd1);
        step();
        chk("wd_err",      64'(err_o),    64'd1);
        chk("wd_dm_valid", 64'(dm_valid), 64'd1);
        chk("wd_rdata",    64'(dm_rdata), 64'd0);
        chk("wd_req_low",  64'(bus_req),  64'd0);
        dm_read = 1'b0;
        step();
        chk("wd_err_pulse", 64'(err_o), 64'd0);
        ack_en = 1'b1;
        step();

        // Reset during the second fetch beat, then restart
        if_addr = 32'h100; if_req = 1'b1;
        step(); step();
        chk("rf_beat1", 64'(bus_addr), 64'h104);
        rst = 1'b0;
        step();
        chk("rf_req",   64'(bus_req),  64'd0);
        chk("rf_addr",  64'(bus_addr), 64'd0);
        chk("rf_inst",  64'(if_inst),  64'd0);
        chk("rf_valid", 64'(if_valid), 64'd0);
        chk("rf_rdata", 64'(dm_rdata), 64'd0);
        rst = 1'b1;
        step();
        chk("rf_restart_req",  64'(bus_req),  64'd1);
        chk("rf_restart_addr", 64'(bus_addr), 64'h100);
        step(); step();
        chk("rf_valid2", 64'(if_valid), 64'd1);
        chk("rf_inst2",  64'(if_inst),  64'h001122334455);
        if_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
